// File: rtl/mult_pkg.sv
// Shared types and width-generic helpers for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE
  } mult_state_e;

  // Mask of the low w bits; w == MAX_W wraps to all ones.
  function automatic logic [MAX_W-1:0] low_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Magnitude of a w-bit two's-complement value; -2^(w-1) maps to 2^(w-1).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] sign_bit;
    sign_bit = MAX_W'(1) << (w - 1);
    return ((x & sign_bit) != '0) ? ((~x + MAX_W'(1)) & low_mask(w)) : (x & low_mask(w));
  endfunction

  // Two's-complement negation of a 2*w-bit product.
  function automatic logic [MAX_W-1:0] neg_2w(input logic [MAX_W-1:0] x, input int unsigned w);
    return (~x + MAX_W'(1)) & low_mask(2 * w);
  endfunction

endpackage

// File: rtl/seq_multiplier_param.sv
// Parametrised multicycle shift-add multiplier with serial operand load,
// per-operation signed/unsigned mode, busy and one-cycle done indication.
module seq_multiplier_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   in_data,
  output logic [2*WIDTH-1:0] out_data,
  output logic               done_o,
  output logic               busy_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  mult_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             in_neg;
  logic [WIDTH-1:0] in_mag;
  logic [PW-1:0]    acc_sum;

  // Operands are loaded as magnitudes; the sign is reapplied to the product.
  assign in_neg  = mode_q & in_data[WIDTH-1];
  assign in_mag  = in_neg ? WIDTH'(abs_w(MAX_W'(in_data), WIDTH)) : in_data;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CALC;
      S_CALC:   if (cnt_q == LAST_IT) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE: if (start_i) mode_d = signed_i;
      S_LOAD_A: begin
        mcand_d = PW'(in_mag);
        neg_d   = in_neg;
      end
      S_LOAD_B: begin
        mplier_d = in_mag;
        neg_d    = neg_q ^ in_neg;
        acc_d    = '0;
        cnt_d    = '0;
      end
      S_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT)
          prod_d = neg_q ? PW'(neg_2w(MAX_W'(acc_sum), WIDTH)) : acc_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign out_data = prod_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;

endmodule
